// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  // Controller operating states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

  // Default performance-counter width and memory-wait watchdog limit
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc_i pulses and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clear_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Next count: clear wins, otherwise step up unless already saturated
  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = '0;
    end else if (inc_i && (value_q != {W{1'b1}})) begin
      value_d = value_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline control: stage enables, IF/ID flush, ID/EX bubble,
// back-end freeze during data-memory waits, a wait watchdog and
// saturating event counters.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_stall_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             back_freeze_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] wait_cnt_o
);

  // Timer only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1
  localparam int          TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             halt_q, halt_d;

  logic mw;
  logic active;

  assign mw     = dmem_req_i & ~dmem_ready_i;
  assign active = (state_q == RUN) || (state_q == MEM_WAIT);

  // Control outputs: memory wait beats load-use stall beats taken branch
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    back_freeze_o = 1'b1;
    if (active) begin
      if (mw) begin
        back_freeze_o = 1'b1;
      end else if (hazard_stall_i) begin
        idex_bubble_o = 1'b1;
        back_freeze_o = 1'b0;
      end else if (branch_taken_i) begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b1;
        back_freeze_o = 1'b0;
      end else begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        back_freeze_o = 1'b0;
      end
    end
  end

  // Next state and watchdog timer; the timer restarts whenever RUN is entered
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          timer_d = '0;
        end
      end
      RUN: begin
        if (mw) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!mw) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d = HALT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    halt_d = (state_d == HALT);
  end

  // State, timer and registered halt flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      halt_q  <= halt_d;
    end
  end

  assign halt_o = halt_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (idex_bubble_o),
    .clear_i (1'b0),
    .value_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (ifid_flush_o),
    .clear_i (1'b0),
    .value_o (flush_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (active & mw),
    .clear_i (1'b0),
    .value_o (wait_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl with narrow counters and a short
// watchdog so saturation and timeout are reachable quickly.
module tb_pipe_stall_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_HALT = 3;

  typedef struct {
    string            tag;
    logic             pcWrite;
    logic             ifidWrite;
    logic             ifidFlush;
    logic             idexBubble;
    logic             backFreeze;
    logic             halt;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;
    logic [CNT_W-1:0] waitCnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             startIn;
  logic             hazardIn;
  logic             branchIn;
  logic             reqIn;
  logic             readyIn;
  logic             pcWrite;
  logic             ifidWrite;
  logic             ifidFlush;
  logic             idexBubble;
  logic             backFreeze;
  logic             haltOut;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;
  logic [CNT_W-1:0] waitCnt;

  int checks;
  int failures;

  int               mState;
  int               mTimer;
  logic             mHalt;
  logic [CNT_W-1:0] mStall;
  logic [CNT_W-1:0] mFlush;
  logic [CNT_W-1:0] mWait;

  exp_t scoreboard[$];

  pipe_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (startIn),
    .hazard_stall_i (hazardIn),
    .branch_taken_i (branchIn),
    .dmem_req_i     (reqIn),
    .dmem_ready_i   (readyIn),
    .pc_write_o     (pcWrite),
    .ifid_write_o   (ifidWrite),
    .ifid_flush_o   (ifidFlush),
    .idex_bubble_o  (idexBubble),
    .back_freeze_o  (backFreeze),
    .halt_o         (haltOut),
    .stall_cnt_o    (stallCnt),
    .flush_cnt_o    (flushCnt),
    .wait_cnt_o     (waitCnt)
  );

  // Free-running clock, posedges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point with failure accounting
  task automatic cmp(input string name, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // Model reset: everything back to idle, counters zero
  task automatic modelReset();
    mState = M_IDLE;
    mTimer = 0;
    mHalt  = 1'b0;
    mStall = '0;
    mFlush = '0;
    mWait  = '0;
  endtask

  // Predict the outputs for the present model state and inputs
  function automatic exp_t predict(input string tag);
    exp_t e;
    logic memWait;
    memWait      = reqIn & ~readyIn;
    e.tag        = tag;
    e.pcWrite    = 1'b0;
    e.ifidWrite  = 1'b0;
    e.ifidFlush  = 1'b0;
    e.idexBubble = 1'b0;
    e.backFreeze = 1'b1;
    if (mState == M_RUN || mState == M_WAIT) begin
      if (memWait) begin
        e.backFreeze = 1'b1;
      end else if (hazardIn) begin
        e.idexBubble = 1'b1;
        e.backFreeze = 1'b0;
      end else if (branchIn) begin
        e.pcWrite    = 1'b1;
        e.ifidWrite  = 1'b1;
        e.ifidFlush  = 1'b1;
        e.backFreeze = 1'b0;
      end else begin
        e.pcWrite    = 1'b1;
        e.ifidWrite  = 1'b1;
        e.backFreeze = 1'b0;
      end
    end
    e.halt     = mHalt;
    e.stallCnt = mStall;
    e.flushCnt = mFlush;
    e.waitCnt  = mWait;
    return e;
  endfunction

  // Advance the model by one clock edge using the inputs held across it
  task automatic modelClock();
    exp_t e;
    logic memWait;
    e       = predict("edge");
    memWait = reqIn & ~readyIn;
    if (e.idexBubble && mStall != CNT_MAX) mStall = mStall + 1'b1;
    if (e.ifidFlush && mFlush != CNT_MAX) mFlush = mFlush + 1'b1;
    if ((mState == M_RUN || mState == M_WAIT) && memWait && mWait != CNT_MAX) mWait = mWait + 1'b1;
    case (mState)
      M_IDLE: if (startIn) begin mState = M_RUN; mTimer = 0; end
      M_RUN:  if (memWait) mState = M_WAIT;
      M_WAIT: begin
        if (!memWait) begin
          mState = M_RUN;
          mTimer = 0;
        end else if (mTimer == TIMEOUT - 1) begin
          mState = M_HALT;
          mHalt  = 1'b1;
        end else begin
          mTimer = mTimer + 1;
        end
      end
      default: mState = M_HALT;
    endcase
  endtask

  // Pop the oldest expectation and compare it with the live outputs
  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (scoreboard.size() > 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      cmp({e.tag, ".pc_write"},      CNT_W'(pcWrite),    CNT_W'(e.pcWrite));
      cmp({e.tag, ".ifid_write"},    CNT_W'(ifidWrite),  CNT_W'(e.ifidWrite));
      cmp({e.tag, ".ifid_flush"},    CNT_W'(ifidFlush),  CNT_W'(e.ifidFlush));
      cmp({e.tag, ".idex_bubble"},   CNT_W'(idexBubble), CNT_W'(e.idexBubble));
      cmp({e.tag, ".back_freeze"},   CNT_W'(backFreeze), CNT_W'(e.backFreeze));
      cmp({e.tag, ".halt"},          CNT_W'(haltOut),    CNT_W'(e.halt));
      cmp({e.tag, ".stall_cnt"},     stallCnt,           e.stallCnt);
      cmp({e.tag, ".flush_cnt"},     flushCnt,           e.flushCnt);
      cmp({e.tag, ".wait_cnt"},      waitCnt,            e.waitCnt);
    end
  endtask

  // One cycle: drive at negedge, predict, check before the posedge, step model
  task automatic applyStimulus(input logic st, input logic hz, input logic br,
                               input logic rq, input logic rd, input string tag);
    @(negedge clk);
    startIn  = st;
    hazardIn = hz;
    branchIn = br;
    reqIn    = rq;
    readyIn  = rd;
    #1;
    scoreboard.push_back(predict(tag));
    #1;
    checkOutput();
    @(posedge clk);
    modelClock();
  endtask

  // Synchronous-looking reset pulse spanning two edges, released at a negedge
  task automatic doReset();
    @(negedge clk);
    startIn  = 1'b0;
    hazardIn = 1'b0;
    branchIn = 1'b0;
    reqIn    = 1'b0;
    readyIn  = 1'b0;
    rst      = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed scenarios followed by a short random burst
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    startIn  = 1'b0;
    hazardIn = 1'b0;
    branchIn = 1'b0;
    reqIn    = 1'b0;
    readyIn  = 1'b0;
    modelReset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    scoreboard.push_back(predict("in_reset"));
    checkOutput();
    rst = 1'b0;

    $display("[TB] start and free run");
    applyStimulus(1, 0, 0, 0, 0, "idle_start");
    applyStimulus(0, 0, 0, 0, 0, "run_first");
    cmp("run_pc_write", CNT_W'(pcWrite), CNT_W'(1'b1));
    cmp("run_freeze", CNT_W'(backFreeze), CNT_W'(1'b0));

    $display("[TB] hazard beats branch");
    applyStimulus(0, 1, 1, 0, 0, "hazard_and_branch");
    applyStimulus(0, 0, 1, 0, 0, "branch_after_hazard");
    applyStimulus(0, 0, 0, 0, 0, "after_branch");
    cmp("stall_cnt_one", stallCnt, CNT_W'(1));
    cmp("flush_cnt_one", flushCnt, CNT_W'(1));

    $display("[TB] three-cycle memory wait");
    applyStimulus(0, 0, 0, 1, 0, "mw_0");
    applyStimulus(0, 1, 0, 1, 0, "mw_1_hazard_masked");
    applyStimulus(0, 0, 1, 1, 0, "mw_2_branch_masked");
    applyStimulus(0, 0, 0, 1, 1, "mw_ready");
    applyStimulus(0, 0, 0, 0, 0, "after_mw");
    cmp("wait_cnt_three", waitCnt, CNT_W'(3));
    cmp("no_halt_after_wait", CNT_W'(haltOut), CNT_W'(1'b0));
    applyStimulus(0, 0, 0, 1, 1, "req_ready_same_cycle");
    applyStimulus(0, 0, 0, 0, 0, "after_zero_wait");
    cmp("wait_cnt_unchanged", waitCnt, CNT_W'(3));

    $display("[TB] watchdog timeout");
    doReset();
    applyStimulus(1, 0, 0, 0, 0, "to_start");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, $sformatf("to_wait_%0d", i));
    applyStimulus(0, 1, 1, 1, 0, "halted_0");
    cmp("halt_after_timeout", CNT_W'(haltOut), CNT_W'(1'b1));
    cmp("wait_cnt_timeout", waitCnt, CNT_W'(5));
    applyStimulus(1, 0, 0, 0, 1, "halted_start_ignored");
    applyStimulus(0, 0, 1, 0, 0, "halted_2");
    doReset();
    applyStimulus(0, 0, 0, 0, 0, "idle_after_halt");
    cmp("halt_cleared", CNT_W'(haltOut), CNT_W'(1'b0));

    $display("[TB] stall counter saturation");
    applyStimulus(1, 0, 0, 0, 0, "sat_start");
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0, $sformatf("sat_%0d", i));
    applyStimulus(0, 0, 0, 0, 0, "sat_done");
    cmp("stall_saturated", stallCnt, CNT_MAX);

    $display("[TB] asynchronous reset during memory wait");
    doReset();
    applyStimulus(1, 0, 0, 0, 0, "ar_start");
    applyStimulus(0, 0, 0, 1, 0, "ar_mw_0");
    applyStimulus(0, 0, 0, 1, 0, "ar_mw_1");
    @(negedge clk);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    scoreboard.push_back(predict("async_reset"));
    checkOutput();
    cmp("async_reset_pc_write", CNT_W'(pcWrite), CNT_W'(1'b0));
    cmp("async_reset_freeze", CNT_W'(backFreeze), CNT_W'(1'b1));
    cmp("async_reset_wait_cnt", waitCnt, CNT_W'(0));
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] random traffic");
    applyStimulus(1, 0, 0, 0, 0, "rnd_start");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    $sformatf("rnd_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
